// File: rtl/avalon_data_arbiter_if.sv
// Bus bundle for one requester or the shared Avalon-MM master port.
// The command travels master->slave; busy and response signals travel back.
interface avalon_data_arbiter_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic              busy;
   logic              rvalid;
   logic              wrespvalid;
   logic [31:0]       rdata;
   logic [1:0]        resp;

   modport master (
      output read, write, addr, be, wdata,
      input  busy, rvalid, wrespvalid, rdata, resp
   );

   modport slave (
      input  read, write, addr, be, wdata,
      output busy, rvalid, wrespvalid, rdata, resp
   );
endinterface

// File: rtl/avalon_data_arbiter.sv
// Two-requester (core, dbg) arbiter onto one pipelined Avalon-MM master with in-order response routing.
// Define ARB_DEBUG_PRIORITY_EN to give dbg strict priority over core instead of round-robin.
module avalon_data_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ADDR_W          = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   avalon_data_arbiter_if.slave  core,
   avalon_data_arbiter_if.slave  dbg,
   avalon_data_arbiter_if.master m,
   output logic                  orphan_o
);
   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;
   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_DBG  = 1'b1;

   logic [0:0]                 r_state;
   logic                       r_owner;
   logic                       r_rr;
   logic [CW-1:0]              r_count;
   logic [PW-1:0]              r_head;
   logic [PW-1:0]              r_tail;
   logic [MAX_OUTSTANDING-1:0] r_fifo;
   logic                       r_orphan;

   logic w_core_req;
   logic w_dbg_req;
   logic w_full;
   logic w_empty;
   logic w_sel;
   logic w_grant;
   logic w_accept;
   logic w_resp;
   logic w_pop;
   logic w_head_own;

   assign w_core_req = core.read | core.write;
   assign w_dbg_req  = dbg.read | dbg.write;
   assign w_full     = (r_count == MAX_CNT);
   assign w_empty    = (r_count == '0);

   // HOLD never sees a full FIFO: nothing is pushed between entering HOLD and leaving it.
   always_comb begin
      w_sel   = OWN_CORE;
      w_grant = 1'b0;
      if (r_state == S_HOLD) begin
         w_sel   = r_owner;
         w_grant = r_owner ? w_dbg_req : w_core_req;
      end else if (!w_full) begin
         if (w_core_req && w_dbg_req) begin
`ifdef ARB_DEBUG_PRIORITY_EN
            w_sel = OWN_DBG;
`else
            w_sel = r_rr;
`endif
         end else begin
            w_sel = w_dbg_req;
         end
         w_grant = w_core_req | w_dbg_req;
      end
      w_grant = w_grant & rst_ni;
   end

   assign w_accept = w_grant & ~m.busy;

   always_comb begin
      m.read  = w_grant & (w_sel ? dbg.read  : core.read);
      m.write = w_grant & (w_sel ? dbg.write : core.write);
      m.addr  = w_sel ? dbg.addr  : core.addr;
      m.be    = w_sel ? dbg.be    : core.be;
      m.wdata = w_sel ? dbg.wdata : core.wdata;
   end

   assign core.busy = ~(w_accept & (w_sel == OWN_CORE));
   assign dbg.busy  = ~(w_accept & (w_sel == OWN_DBG));

   assign w_resp     = m.rvalid | m.wrespvalid;
   assign w_pop      = w_resp & ~w_empty & rst_ni;
   assign w_head_own = r_fifo[r_head];

   assign core.rvalid     = w_pop & m.rvalid     & (w_head_own == OWN_CORE);
   assign core.wrespvalid = w_pop & m.wrespvalid & (w_head_own == OWN_CORE);
   assign dbg.rvalid      = w_pop & m.rvalid     & (w_head_own == OWN_DBG);
   assign dbg.wrespvalid  = w_pop & m.wrespvalid & (w_head_own == OWN_DBG);
   assign core.rdata      = m.rdata;
   assign core.resp       = m.resp;
   assign dbg.rdata       = m.rdata;
   assign dbg.resp        = m.resp;

   assign orphan_o = r_orphan;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_owner <= OWN_CORE;
         r_rr    <= OWN_CORE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant && m.busy) begin
                  r_state <= S_HOLD;
                  r_owner <= w_sel;
               end
            end
            S_HOLD: begin
               if (!w_grant || !m.busy) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_accept) r_rr <= ~w_sel;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fifo   <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_orphan <= 1'b0;
      end else begin
         if (w_accept) begin
            r_fifo[r_tail] <= w_sel;
            r_tail         <= r_tail + 1'b1;
         end
         if (w_pop) r_head <= r_head + 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_resp && w_empty) r_orphan <= 1'b1;
      end
   end
endmodule

// File: tb/tb_avalon_data_arbiter.sv
// Directed bench for avalon_data_arbiter: expected grants and responses are queued
// by the stimulus and consumed by an independent monitor.
module tb_avalon_data_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic orphan;
   int   checks = 0;
   int   failures = 0;

   typedef logic [33:0] gnt_t; // {who, is_write, addr}
   typedef logic [36:0] rsp_t; // {both_ports, who, is_wresp, rdata, resp}
   gnt_t gq[$];
   rsp_t rq[$];

   avalon_data_arbiter_if #(.ADDR_W(32)) core_if ();
   avalon_data_arbiter_if #(.ADDR_W(32)) dbg_if ();
   avalon_data_arbiter_if #(.ADDR_W(32)) m_if ();

   avalon_data_arbiter #(.MAX_OUTSTANDING(4), .ADDR_W(32)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .core     (core_if),
      .dbg      (dbg_if),
      .m        (m_if),
      .orphan_o (orphan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic gnt_t g(input logic who, input logic isw, input logic [31:0] a);
      return {who, isw, a};
   endfunction

   function automatic rsp_t r(input logic who, input logic isw, input logic [31:0] d, input logic [1:0] rc);
      return {1'b0, who, isw, d, rc};
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clr_resp();
      m_if.rvalid = 1'b0; m_if.wrespvalid = 1'b0; m_if.rdata = '0; m_if.resp = '0;
   endtask

   task automatic idle_inputs();
      core_if.read = 1'b0; core_if.write = 1'b0; core_if.addr = '0; core_if.be = 4'hF; core_if.wdata = '0;
      dbg_if.read  = 1'b0; dbg_if.write  = 1'b0; dbg_if.addr  = '0; dbg_if.be  = 4'hF; dbg_if.wdata  = '0;
      m_if.busy = 1'b0;
      clr_resp();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      nxt();
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic respond(input logic isw, input logic [31:0] d, input logic [1:0] rc, input logic who);
      m_if.rvalid = ~isw; m_if.wrespvalid = isw; m_if.rdata = d; m_if.resp = rc;
      rq.push_back(r(who, isw, d, rc));
      smp();
      nxt();
      clr_resp();
   endtask

   // Monitor: every accepted command and every forwarded response is matched against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if ((m_if.read || m_if.write) && !m_if.busy) begin
            if (gq.size() == 0) begin
               checks++; failures++;
               $display("FAIL grant_unexp: got addr 0x%0h expected no grant", m_if.addr);
            end else begin
               chk("grant", {30'd0, ~dbg_if.busy, m_if.write, m_if.addr}, {30'd0, gq.pop_front()});
            end
         end
         if (core_if.rvalid || core_if.wrespvalid || dbg_if.rvalid || dbg_if.wrespvalid) begin
            logic dv, cv;
            rsp_t act;
            cv  = core_if.rvalid | core_if.wrespvalid;
            dv  = dbg_if.rvalid | dbg_if.wrespvalid;
            act = {cv & dv, dv, core_if.wrespvalid | dbg_if.wrespvalid,
                   dv ? dbg_if.rdata : core_if.rdata, dv ? dbg_if.resp : core_if.resp};
            if (rq.size() == 0) begin
               checks++; failures++;
               $display("FAIL resp_unexp: got 0x%0h expected no response", act);
            end else begin
               chk("response", {27'd0, act}, {27'd0, rq.pop_front()});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      // Reset state with live inputs on every side
      core_if.read = 1'b1; core_if.addr = 32'h100; m_if.rvalid = 1'b1; m_if.rdata = 32'h55;
      smp();
      chk("rst_m_read", m_if.read, 0);
      chk("rst_core_busy", core_if.busy, 1);
      chk("rst_dbg_busy", dbg_if.busy, 1);
      chk("rst_core_rvalid", core_if.rvalid, 0);
      chk("rst_orphan", orphan, 0);
      nxt();
      do_reset();

      // Single core read, response two cycles later
      core_if.read = 1'b1; core_if.addr = 32'h100;
      gq.push_back(g(0, 0, 32'h100));
      smp();
      chk("t1_m_read", m_if.read, 1);
      chk("t1_core_busy", core_if.busy, 0);
      chk("t1_m_addr", m_if.addr, 32'h100);
      nxt();
      core_if.read = 1'b0;
      nxt();
      m_if.rvalid = 1'b1; m_if.rdata = 32'hDEADBEEF;
      rq.push_back(r(0, 0, 32'hDEADBEEF, 2'b00));
      smp();
      chk("t1_core_rvalid", core_if.rvalid, 1);
      chk("t1_dbg_rvalid", dbg_if.rvalid, 0);
      nxt();
      clr_resp();

      // Both request every cycle
      do_reset();
      core_if.read = 1'b1; core_if.addr = 32'h200;
      dbg_if.write = 1'b1; dbg_if.addr = 32'h300; dbg_if.wdata = 32'h3;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_DEBUG_PRIORITY_EN
         gq.push_back(g(1, 1, 32'h300));
`else
         if (i % 2 == 0) gq.push_back(g(0, 0, 32'h200));
         else            gq.push_back(g(1, 1, 32'h300));
`endif
         smp();
         nxt();
      end
      idle_inputs();
      nxt();
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_DEBUG_PRIORITY_EN
         respond(1, 32'hA000_0000 + i, 2'(i), 1);
`else
         respond(1'(i % 2), 32'hA000_0000 + i, 2'(i), 1'(i % 2));
`endif
      end

      // Dbg write held by waitrequest while core waits
      do_reset();
      core_if.read = 1'b1; core_if.addr = 32'h50;
      gq.push_back(g(0, 0, 32'h50));
      smp();
      nxt();
      core_if.addr = 32'h500;
      dbg_if.write = 1'b1; dbg_if.addr = 32'h400; dbg_if.wdata = 32'h1234;
      m_if.busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t3_hold_addr", m_if.addr, 32'h400);
         chk("t3_hold_write", m_if.write, 1);
         chk("t3_hold_core_busy", core_if.busy, 1);
         nxt();
      end
      m_if.busy = 1'b0;
      gq.push_back(g(1, 1, 32'h400));
      smp();
      chk("t3_dbg_busy", dbg_if.busy, 0);
      chk("t3_core_busy", core_if.busy, 1);
      nxt();
      dbg_if.write = 1'b0;
      gq.push_back(g(0, 0, 32'h500));
      smp();
      chk("t3_core_next", core_if.busy, 0);
      nxt();
      core_if.read = 1'b0;
      nxt();
      respond(0, 32'hB0, 2'b00, 0);
      respond(1, 32'hB1, 2'b10, 1);
      respond(0, 32'hB2, 2'b00, 0);

      // FIFO full: fifth read stalls until a response frees a slot
      do_reset();
      core_if.read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         core_if.addr = 32'h600 + 32'(4 * i);
         gq.push_back(g(0, 0, core_if.addr));
         smp();
         nxt();
      end
      core_if.addr = 32'h610;
      smp();
      chk("t4_full_busy", core_if.busy, 1);
      chk("t4_full_m_read", m_if.read, 0);
      nxt();
      m_if.rvalid = 1'b1; m_if.rdata = 32'h11;
      rq.push_back(r(0, 0, 32'h11, 2'b00));
      smp();
      chk("t4_pop_busy", core_if.busy, 1);
      chk("t4_pop_m_read", m_if.read, 0);
      nxt();
      clr_resp();
      gq.push_back(g(0, 0, 32'h610));
      smp();
      chk("t4_accept_busy", core_if.busy, 0);
      nxt();
      core_if.read = 1'b0;
      for (int i = 0; i < 4; i++) respond(0, 32'h12 + i, 2'b00, 0);

      // Push and pop in the same cycle at count 2
      do_reset();
      core_if.read = 1'b1; core_if.addr = 32'h700;
      gq.push_back(g(0, 0, 32'h700));
      smp();
      nxt();
      core_if.read = 1'b0;
      dbg_if.read = 1'b1; dbg_if.addr = 32'h704;
      gq.push_back(g(1, 0, 32'h704));
      smp();
      nxt();
      dbg_if.read = 1'b0;
      core_if.read = 1'b1; core_if.addr = 32'h708;
      gq.push_back(g(0, 0, 32'h708));
      m_if.rvalid = 1'b1; m_if.rdata = 32'h21;
      rq.push_back(r(0, 0, 32'h21, 2'b00));
      smp();
      chk("t5_core_busy", core_if.busy, 0);
      nxt();
      core_if.read = 1'b0;
      clr_resp();
      respond(0, 32'h22, 2'b00, 1);
      respond(0, 32'h23, 2'b00, 0);
      chk("t5_orphan_before", orphan, 0);
      m_if.wrespvalid = 1'b1;
      smp();
      chk("t5_extra_core", core_if.wrespvalid, 0);
      chk("t5_extra_dbg", dbg_if.wrespvalid, 0);
      nxt();
      clr_resp();
      smp();
      chk("t5_orphan_after", orphan, 1);
      nxt();

      // Orphan response on a freshly reset arbiter, sticky until reset
      do_reset();
      smp();
      chk("t6_orphan_clear", orphan, 0);
      nxt();
      m_if.wrespvalid = 1'b1; m_if.rdata = 32'h77;
      smp();
      chk("t6_core_wresp", core_if.wrespvalid, 0);
      chk("t6_dbg_wresp", dbg_if.wrespvalid, 0);
      nxt();
      clr_resp();
      nxt();
      nxt();
      smp();
      chk("t6_orphan_sticky", orphan, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_orphan_reset", orphan, 0);
      nxt();
      rst_n = 1'b1;
      nxt();

      chk("grant_queue_empty", gq.size(), 0);
      chk("resp_queue_empty", rq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/avalon_data_arbiter.md
Name: avalon_data_arbiter

Overview:
- Shares one pipelined Avalon-MM master port between two requesters: the Ibex data bus (core) and the debug-module system-bus-access host (dbg).
- Both requesters use the busy/rvalid/wrespvalid convention of the integration wrapper.
- Arbitrates commands, holds ownership while waitrequest stalls a command, and tracks outstanding transactions in an in-order owner FIFO so read and write responses are routed back to the issuer.

Parameters:
- MAX_OUTSTANDING, 4: depth of the owner FIFO; maximum accepted-but-unanswered commands (power of two, ≥2).
- ADDR_W, 32: address width on all ports.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_read / core_write  in  1  core command strobes (never both high)
- core_addr  in  ADDR_W  core address
- core_be  in  4  core byte enables
- core_wdata  in  32  core write data
- core_busy  out  1  core stall; command accepted in a cycle where strobe=1 and busy=0
- core_rvalid  out  1  read data valid to core
- core_wrespvalid  out  1  write response valid to core
- core_rdata  out  32  read data to core
- core_resp  out  2  response code to core
- dbg_read, dbg_write, dbg_addr, dbg_be, dbg_wdata, dbg_busy, dbg_rvalid, dbg_wrespvalid, dbg_rdata, dbg_resp: identical set for the debug SBA host
- m_read / m_write  out  1  master command strobes
- m_addr  out  ADDR_W  master address
- m_be  out  4  master byte enables
- m_wdata  out  32  master write data
- m_busy  in  1  Avalon waitrequest
- m_rvalid  in  1  readdatavalid
- m_wrespvalid  in  1  writeresponsevalid
- m_rdata  in  32  read data
- m_resp  in  2  response code
- orphan_o  out  1  sticky: response arrived with owner FIFO empty

Behaviour:
- Clocking and reset:
  - Single clock clk_i; asynchronous active-low reset rst_ni.
  - Reset clears the FIFO (count=0), sets state=IDLE, rr_ptr=core and orphan_o=0.
  - While in reset: m_read=m_write=0, core_busy=dbg_busy=1, all rvalid/wrespvalid=0.
- Downstream ordering: the fabric returns responses strictly in command order, reads and writes interleaved.
- States: IDLE and HOLD.
- IDLE:
  - Candidates are requesters with read|write asserted.
  - No grant when count==MAX_OUTSTANDING, even if a response pops in the same cycle.
  - One candidate: that candidate wins. Two candidates: the winner is the one rr_ptr points to.
  - The winner's command is driven combinationally onto m_* in the same cycle (zero added latency).
  - m_busy=0: the command is accepted, the owner ID is pushed, and rr_ptr moves to the other requester.
  - m_busy=1: latch owner and go to HOLD.
- HOLD:
  - The latched owner's command stays muxed to m_*; the other requester sees busy=1.
  - On m_busy=0: accept, push, advance rr_ptr, return to IDLE.
  - If the owner drops both strobes (protocol violation): m_read=m_write=0 that cycle, return to IDLE, no push.
- Busy outputs:
  - x_busy = ~(x is the selected winner/owner & ~m_busy & count<MAX).
  - A non-requesting port may show busy=1.
- Responses:
  - m_rvalid or m_wrespvalid pops the FIFO head and forwards rvalid/wrespvalid, rdata and resp to the head owner in the same cycle (combinational).
  - Non-owner rvalid/wrespvalid stay 0.
  - rdata/resp are broadcast to both ports; they are meaningful only with valid.
- Simultaneous push and pop: count unchanged; head and tail pointers both advance.
- Pointer wrap: modulo MAX_OUTSTANDING.
- Response with count==0: dropped (no valid to either port) and orphan_o set; it clears only on reset.
- Reset mid-transaction: outstanding responses arriving after reset are treated as orphans.

Optional Feature:
- Macro: ARB_DEBUG_PRIORITY_EN.
- Defined: dbg wins over core whenever both request in IDLE (strict priority); rr_ptr is unused.
- Undefined: round-robin as above.
- HOLD locking and FIFO behaviour are identical in both builds.

Test Plan:
- Core read addr 0x100 alone, m_busy=0, m_rvalid 2 cycles later with rdata 0xDEADBEEF -> m_read=1 same cycle, core_busy=0, core_rvalid=1 with 0xDEADBEEF, dbg_rvalid=0.
- Core and dbg request every cycle, m_busy=0 -> grants alternate core, dbg, core, dbg; responses in order go to the matching port (build without macro). With ARB_DEBUG_PRIORITY_EN, dbg gets every grant.
- Dbg write held with m_busy=1 for 3 cycles while core also requests -> m_addr stays the dbg address all 3 cycles, core_busy=1; on m_busy=0 dbg is accepted, then core is granted next cycle.
- Core issues 4 reads with no responses (MAX_OUTSTANDING=4) -> 5th read sees core_busy=1 with m_read=0; one m_rvalid -> next cycle the 5th read is accepted.
- Same-cycle response pop and new accept at count=2 -> count stays 2, routing order preserved.
- m_wrespvalid with empty FIFO -> no port valid, orphan_o=1 until rst_ni asserted low.
